// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial link and the sample-output sequencer.
//   FRAME_BITS  : bits per SPI frame (control byte + sample)
//   SAMPLE_BITS : bits per audio sample
//   CMD_LOAD_A/B: DAC control bytes that load channel A (left) / B (right)
//   spi_state_e : serialiser FSM state encoding, also exported on the debug port
package dac_pkg;

  localparam int FRAME_BITS  = 24;
  localparam int SAMPLE_BITS = 16;
  localparam int BIT_CNT_W   = 5;

  localparam logic [7:0] CMD_LOAD_A = 8'h31;
  localparam logic [7:0] CMD_LOAD_B = 8'h32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_half_period_tick.sv
// Half-period divider for the SPI serial clock.
//   i_Clock   : system clock
//   i_Reset_n : asynchronous active-low reset
//   i_Clear   : restart the divider phase (frame start)
//   i_Enable  : count while a frame is on the wire
//   o_Tick    : one-cycle pulse on the last cycle of every CLOCK_DIVIDE-cycle window
module spi_half_period_tick #(
  parameter int CLOCK_DIVIDE = 2
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tick
);

  localparam int             CW   = $clog2(CLOCK_DIVIDE + 1);
  localparam logic [CW-1:0]  LAST = CW'(CLOCK_DIVIDE - 1);

  logic [CW-1:0] r_count;

  assign o_Tick = i_Enable && !i_Clear && (r_count == LAST);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_count <= '0;
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (i_Enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/dac_spi_serialiser.sv
// Serialises one 24-bit DAC command word (control byte + sample) onto a
// 3-wire SPI link, SPI mode 1 (SCLK idles low, MOSI changes on SCLK rise,
// DAC samples on SCLK fall).
//   i_Clock     : system clock
//   i_Reset_n   : asynchronous active-low reset
//   i_Data      : frame word, MSB first
//   i_Send      : level request, taken only while o_Ready=1
//   o_Ready     : idle, accepts i_Send this cycle
//   o_SPI_CS    : DAC SYNC, active-low
//   o_SPI_clock : SCLK
//   o_SPI_data  : MOSI
//   o_Dbg_state : current FSM state
// Handshake: a frame is accepted on any rising clock edge where o_Ready=1
// and i_Send=1; i_Data is captured on that edge only. o_Ready drops on the
// following cycle and stays low until the frame and the CS idle gap are done.
import dac_pkg::*;

module dac_spi_serialiser #(
  parameter int CLOCK_DIVIDE = 2,
  parameter int CS_IDLE      = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic [FRAME_BITS-1:0] i_Data,
  input  logic                  i_Send,
  output logic                  o_Ready,
  output logic                  o_SPI_CS,
  output logic                  o_SPI_clock,
  output logic                  o_SPI_data,
  output spi_state_e            o_Dbg_state
);

  localparam int                    GW       = $clog2(CS_IDLE + 1);
  localparam logic [GW-1:0]         GAP_LAST = GW'(CS_IDLE - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_TOP  = BIT_CNT_W'(FRAME_BITS - 1);

  spi_state_e             r_state,   w_state_nxt;
  logic [FRAME_BITS-1:0]  r_shift,   w_shift_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [GW-1:0]          r_gap_cnt, w_gap_cnt_nxt;
  logic                   r_cs,      w_cs_nxt;
  logic                   r_sclk,    w_sclk_nxt;
  logic                   r_mosi,    w_mosi_nxt;
  logic                   r_ready,   w_ready_nxt;

  logic w_accept;
  logic w_tick;

  assign w_accept = (r_state == ST_IDLE) && i_Send;

  spi_half_period_tick #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_tick (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Clear   (w_accept),
    .i_Enable  ((r_state == ST_SETUP) || (r_state == ST_SHIFT)),
    .o_Tick    (w_tick)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_cs      <= w_cs_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_cs_nxt      = r_cs;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_ready_nxt   = r_ready;

    case (r_state)
      ST_IDLE: begin
        if (i_Send) begin
          w_state_nxt   = ST_SETUP;
          w_shift_nxt   = i_Data;
          w_bit_cnt_nxt = BIT_TOP;
          w_cs_nxt      = 1'b0;
          w_sclk_nxt    = 1'b0;
          w_mosi_nxt    = i_Data[FRAME_BITS-1];
          w_ready_nxt   = 1'b0;
        end
      end

      ST_SETUP: begin
        // MSB is already on MOSI, so the first rise only raises SCLK.
        if (w_tick) begin
          w_state_nxt = ST_SHIFT;
          w_sclk_nxt  = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
          end else if (r_bit_cnt == '0) begin
            // End of the last low phase: release CS and start the idle gap.
            w_state_nxt   = ST_GAP;
            w_cs_nxt      = 1'b1;
            w_mosi_nxt    = 1'b0;
            w_gap_cnt_nxt = '0;
          end else begin
            // Next bit goes out together with the rising edge.
            w_sclk_nxt    = 1'b1;
            w_shift_nxt   = {r_shift[FRAME_BITS-2:0], 1'b0};
            w_mosi_nxt    = r_shift[FRAME_BITS-2];
            w_bit_cnt_nxt = r_bit_cnt - BIT_CNT_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign o_Ready     = r_ready;
  assign o_SPI_CS    = r_cs;
  assign o_SPI_clock = r_sclk;
  assign o_SPI_data  = r_mosi;
  assign o_Dbg_state = r_state;

endmodule

// File: doc/dac_spi_serialiser.md
# dac_spi_serialiser

Serialises one 24-bit DAC command word (8-bit control byte + 16-bit sample) onto a 3-wire SPI link (CS, SCLK, MOSI) for the stereo 16-bit DAC. Sits directly downstream of the stereo sample-output sequencer, which drives it with a level-held send/ready handshake once per channel per sample period. Produces the board's DAC pins directly.

## Interface
- CLOCK_DIVIDE, 2, system clocks per SCLK half-period (≥1)
- CS_IDLE, 2, system clocks CS stays high after a frame before o_Ready rises (≥1)
- i_Clock  in  1  system clock; all logic on rising edge
- i_Reset_n  in  1  reset, asynchronous assert, active-low
- i_Data  in  24  frame word, MSB first: [23:16] control byte, [15:0] sample
- i_Send  in  1  level request; sampled only while o_Ready=1
- o_Ready  out  1  high = idle, will accept i_Send this cycle
- o_SPI_CS  out  1  DAC SYNC, active-low
- o_SPI_clock  out  1  SCLK, idles low
- o_SPI_data  out  1  MOSI

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values (immediate on i_Reset_n low): o_SPI_CS=1, o_SPI_clock=0, o_SPI_data=0, o_Ready=1, state IDLE, counters 0.
- SPI mode 1 (CPOL=0, CPHA=1): data changes with SCLK rising, DAC samples on SCLK falling.
- States:
  - IDLE: o_Ready=1, CS=1. i_Send=1 → latch i_Data into shift register, go SETUP.
  - SETUP: CS=0, SCLK=0, MOSI=bit23; CLOCK_DIVIDE cycles → SHIFT.
  - SHIFT: 24 bit periods, each CLOCK_DIVIDE cycles SCLK=1, then CLOCK_DIVIDE cycles SCLK=0. MOSI updates to next bit in the cycle SCLK rises (bit23 already present for first). After 24th low phase → GAP.
  - GAP: CS=1, SCLK=0, MOSI=0, o_Ready=0 for CS_IDLE cycles → IDLE.
- Counters: half-period counter width $clog2(CLOCK_DIVIDE+1); bit counter 5 bits, counts 23 down to 0, no wrap past 0.
- i_Data changes after acceptance: ignored until next acceptance.
- i_Send while busy: ignored. i_Send still high on the cycle IDLE is re-entered: a new frame starts (upstream must drop i_Send once o_Ready falls).
- Reset mid-frame: frame aborted, CS high at once; DAC discards frames with <24 falling edges, so no partial update.
- All outputs registered; no combinational path input→output.

## Timing
- Accept at edge T0 (IDLE, i_Send=1). From T0+1: o_Ready=0, CS=0, MOSI=i_Data[23].
- First SCLK rise at T0+1+CLOCK_DIVIDE; bit k (23..0) falling edge at T0+1+CLOCK_DIVIDE·(2·(23−k)+2).
- CS rises at T0+1+49·CLOCK_DIVIDE; o_Ready rises at T0+1+49·CLOCK_DIVIDE+CS_IDLE.
- Defaults: 24 falling edges, CS low 98 cycles, o_Ready low 100 cycles; earliest next accept at T0+101.
- SCLK frequency = f_clk / (2·CLOCK_DIVIDE).

## Structure
- Shared package dac_pkg: FRAME_BITS=24, SAMPLE_BITS=16, DAC command bytes CMD_LOAD_A=8'h31, CMD_LOAD_B=8'h32 (also used by sample-output sequencer).
- Single optional sub-module spi_half_period_tick: divider emitting 1-cycle tick every CLOCK_DIVIDE cycles, cleared on frame start; FSM + shift register in top.

## Test plan
- Reset: hold i_Reset_n=0 with i_Send=1 → CS=1, SCLK=0, MOSI=0, o_Ready=1; no SCLK edges.
- Single frame, defaults, i_Data=24'h31ABCD, i_Send dropped when o_Ready falls → bench SPI monitor captures 24'h31ABCD on falling edges, exactly 24 edges, CS low 98 cycles, o_Ready high 101 cycles after accept.
- Back-to-back L/R as upstream sequencer: 24'h318000 then 24'h327FFF → two frames, CS-high gap ≥2 cycles, both words correct.
- i_Send held high continuously, i_Data changing mid-frame → frames repeat every 101 cycles, each carrying word present on its accept cycle only.
- CLOCK_DIVIDE=1, CS_IDLE=1, i_Data=24'hFFFFFF then 24'h000000 → SCLK = f_clk/2, CS low 49 cycles, correct words.
- Async reset asserted after 10 falling edges → CS high same cycle (no clock edge needed), SCLK low, o_Ready=1; next send after release yields a complete clean frame.
